// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: one bit position per cycle through
// the shared ALU, with RCL/RCR rotated locally through a private carry.
module shift_sequencer #(
  parameter logic [4:0] CNT_MASK = 5'h1F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic        size,
  input  logic [15:0] operand,
  input  logic [7:0]  count,
  input  logic [5:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [5:0]  flags_out,
  output logic [4:0]  alu_op,
  output logic        alu_size,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_r,
  input  logic [5:0]  alu_flags
);

  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ROLC = 5'd10;
  localparam logic [4:0] OP_RORC = 5'd11;
  localparam logic [4:0] OP_SHL  = 5'd12;
  localparam logic [4:0] OP_SHR  = 5'd13;
  localparam logic [4:0] OP_SHLA = 5'd14;
  localparam logic [4:0] OP_SHRA = 5'd15;

  localparam int FL_CY = 1;
  localparam int FL_V  = 2;
  localparam int FL_P  = 3;
  localparam int FL_S  = 4;
  localparam int FL_Z  = 5;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  fl_q, fl_d;
  logic [4:0]  op_q, op_d;
  logic        size_q, size_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] res_q, res_d;
  logic [5:0]  flo_q, flo_d;

  logic [4:0]  cnt_in;
  logic        op_ok;
  logic        is_rolc;
  logic        is_rorc;
  logic        upd_zsp;
  logic        old_msb;
  logic        new_msb;
  logic [15:0] step_acc;
  logic [5:0]  step_fl;

  assign cnt_in  = count[4:0] & CNT_MASK;
  assign op_ok   = (op[4:3] == 2'b01);
  assign is_rolc = (op_q == OP_ROLC);
  assign is_rorc = (op_q == OP_RORC);
  assign upd_zsp = (op_q == OP_SHL) || (op_q == OP_SHLA) ||
                   (op_q == OP_SHR) || (op_q == OP_SHRA);
  assign old_msb = size_q ? acc_q[15] : acc_q[7];
  assign new_msb = size_q ? step_acc[15] : step_acc[7];

  always_comb begin
    step_acc = acc_q;
    step_fl  = fl_q;
    unique case (1'b1)
      is_rolc: begin
        if (size_q) begin
          {step_fl[FL_CY], step_acc} = {acc_q, fl_q[FL_CY]};
        end else begin
          {step_fl[FL_CY], step_acc[7:0]} =
            {acc_q[7:0], fl_q[FL_CY]};
        end
      end
      is_rorc: begin
        if (size_q) begin
          {step_acc, step_fl[FL_CY]} = {fl_q[FL_CY], acc_q};
        end else begin
          {step_acc[7:0], step_fl[FL_CY]} =
            {fl_q[FL_CY], acc_q[7:0]};
        end
      end
      default: begin
        step_acc       = alu_r;
        step_fl[FL_CY] = alu_flags[FL_CY];
        if (upd_zsp) begin
          step_fl[FL_Z] = alu_flags[FL_Z];
          step_fl[FL_S] = alu_flags[FL_S];
          step_fl[FL_P] = alu_flags[FL_P];
        end
      end
    endcase
    // Byte ops never disturb the upper half, whatever the ALU returns.
    if (!size_q) step_acc[15:8] = acc_q[15:8];
    step_fl[FL_V] = (op_q == OP_SHR) ? old_msb : (old_msb ^ new_msb);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    op_d    = op_q;
    size_d  = size_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    flo_d   = flo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d  = operand;
          cnt_d  = cnt_in;
          fl_d   = flags_in;
          op_d   = op;
          size_d = size;
          busy_d = 1'b1;
          if (cnt_in == 5'd0 || !op_ok) begin
            state_d = DONE;
            done_d  = 1'b1;
            res_d   = operand;
            flo_d   = flags_in;
          end else begin
            state_d = STEP;
          end
        end
      end
      STEP: begin
        acc_d = step_acc;
        fl_d  = step_fl;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
          res_d   = step_acc;
          flo_d   = step_fl;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 16'h0;
      cnt_q   <= 5'd0;
      fl_q    <= 6'h0;
      op_q    <= OP_ROL;
      size_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 16'h0;
      flo_q   <= 6'h0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      op_q    <= op_d;
      size_q  <= size_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      flo_q   <= flo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign flags_out = flo_q;
  assign alu_op    = (op_q == OP_SHLA) ? OP_SHL : op_q;
  assign alu_size  = size_q;
  assign alu_a     = acc_q;
  assign alu_b     = (state_q == STEP) ? 16'd1 : 16'd0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a one-bit-per-call ALU model
// answering the sequencer's ALU requests.
module tb_shift_sequencer;

  localparam logic [4:0] ROL  = 5'd8;
  localparam logic [4:0] ROR  = 5'd9;
  localparam logic [4:0] ROLC = 5'd10;
  localparam logic [4:0] RORC = 5'd11;
  localparam logic [4:0] SHL  = 5'd12;
  localparam logic [4:0] SHR  = 5'd13;
  localparam logic [4:0] SHLA = 5'd14;
  localparam logic [4:0] SHRA = 5'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = 5'd0;
  logic        size = 1'b0;
  logic [15:0] operand = 16'h0;
  logic [7:0]  count = 8'h0;
  logic [5:0]  flags_in = 6'h0;
  logic        busy, done;
  logic [15:0] result;
  logic [5:0]  flags_out;
  logic [4:0]  alu_op;
  logic        alu_size;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_r;
  logic [5:0]  alu_flags;

  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .size(size), .operand(operand), .count(count),
    .flags_in(flags_in), .busy(busy), .done(done),
    .result(result), .flags_out(flags_out), .alu_op(alu_op),
    .alu_size(alu_size), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: byte results carry junk in the upper byte, AC/V junk set.
  logic [15:0] a, r;
  logic        cy;
  always_comb begin
    a  = alu_a;
    r  = 16'h0;
    cy = 1'b0;
    if (alu_b == 16'd1) begin
      case (alu_op)
        ROL: begin
          r  = alu_size ? {a[14:0], a[15]} : {8'hFF, a[6:0], a[7]};
          cy = alu_size ? a[15] : a[7];
        end
        ROR: begin
          r  = alu_size ? {a[0], a[15:1]} : {8'hFF, a[0], a[7:1]};
          cy = a[0];
        end
        SHL: begin
          r  = alu_size ? {a[14:0], 1'b0} : {8'hFF, a[6:0], 1'b0};
          cy = alu_size ? a[15] : a[7];
        end
        SHR: begin
          r  = alu_size ? {1'b0, a[15:1]} : {8'hFF, 1'b0, a[7:1]};
          cy = a[0];
        end
        SHRA: begin
          r  = alu_size ? {a[15], a[15:1]} : {8'hFF, a[7], a[7:1]};
          cy = a[0];
        end
        default: begin
          r  = 16'h0;
          cy = 1'b0;
        end
      endcase
    end
    alu_r        = r;
    alu_flags[0] = 1'b1;
    alu_flags[1] = cy;
    alu_flags[2] = 1'b1;
    alu_flags[3] = ~^r[7:0];
    alu_flags[4] = alu_size ? r[15] : r[7];
    alu_flags[5] = alu_size ? (r == 16'h0) : (r[7:0] == 8'h0);
  end

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [5:0]  fl;
    int          lat;
    int          issue;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int dones  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none",
                 cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
        chk({e.name, "_flags"}, {26'h0, flags_out}, {26'h0, e.fl});
        chk({e.name, "_latency"}, cyc - e.issue, e.lat);
        chk({e.name, "_busy"}, {31'h0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle",
               nm, n);
    end
  endtask

  task automatic issue(input string nm, input logic [4:0] o,
                       input logic s, input logic [15:0] v,
                       input logic [7:0] c, input logic [5:0] f,
                       input logic [15:0] er, input logic [5:0] ef,
                       input int lat, input bit hold);
    exp_t e;
    op = o; size = s; operand = v; count = c; flags_in = f;
    start = 1'b1;
    e.name = nm; e.res = er; e.fl = ef; e.lat = lat; e.issue = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    operand  = ~v;
    flags_in = ~f;
    count    = 8'd1;
    op       = SHL;
    if (hold) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle(nm);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_flags", {26'h0, flags_out}, 32'h0);
    chk("rst_alu_op", {27'h0, alu_op}, {27'h0, ROL});
    chk("rst_alu_a", {16'h0, alu_a}, 32'h0);
    chk("rst_alu_b", {16'h0, alu_b}, 32'h0);

    issue("shl_b", SHL, 1'b0, 16'h0081, 8'd1, 6'h00,
          16'h0002, 6'b000110, 2, 1'b0);
    issue("rol_w", ROL, 1'b1, 16'h8001, 8'd4, 6'b111011,
          16'h0018, 6'b111001, 5, 1'b0);
    issue("rcl_b", ROLC, 1'b0, 16'h3480, 8'd9, 6'h00,
          16'h3480, 6'b000100, 10, 1'b0);
    issue("shr_w", SHR, 1'b1, 16'h8000, 8'h21, 6'h00,
          16'h4000, 6'b001100, 2, 1'b0);
    issue("cnt20", SHL, 1'b1, 16'hBEEF, 8'h20, 6'h2A,
          16'hBEEF, 6'h2A, 1, 1'b0);
    issue("rcr_w", RORC, 1'b1, 16'h0001, 8'd1, 6'b100000,
          16'h0000, 6'b100010, 2, 1'b0);
    issue("shra_b", SHRA, 1'b0, 16'h1290, 8'd2, 6'h00,
          16'h12E4, 6'b011000, 3, 1'b0);
    issue("ror_b", ROR, 1'b0, 16'h5501, 8'd3, 6'b000111,
          16'h5520, 6'b000001, 4, 1'b0);
    issue("shla_w", SHLA, 1'b1, 16'h4000, 8'd1, 6'h00,
          16'h8000, 6'b011100, 2, 1'b0);
    issue("shl_w17", SHL, 1'b1, 16'h0001, 8'd17, 6'h00,
          16'h0000, 6'b101000, 18, 1'b0);
    issue("badop", 5'd3, 1'b0, 16'h1234, 8'd5, 6'h15,
          16'h1234, 6'h15, 1, 1'b1);
    repeat (2) @(negedge clk);
    chk("done_start_ignored", {31'h0, busy}, 32'd0);

    begin
      int t0;
      int d0;
      op = SHL; size = 1'b1; operand = 16'h0001;
      count = 8'd31; flags_in = 6'h00;
      start = 1'b1;
      t0 = cyc;
      d0 = dones;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (cyc < t0 + 10) @(negedge clk);
      chk("abort_busy_before", {31'h0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_done", {31'h0, done}, 32'd0);
      chk("abort_result", {16'h0, result}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_done", dones - d0, 0);
      chk("abort_idle", {31'h0, busy}, 32'd0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
